// File: rtl/multes_ipcore_pkg.sv
// Shared definitions for the packet decision applier: state encoding, data width
// and buffer sizing helpers.
package multes_ipcore_pkg;

  localparam int DEFAULT_DEPTH = 64;
  localparam int DATA_W        = 512;

  localparam logic [1:0] ST_FILL_ENC     = 2'd0;
  localparam logic [1:0] ST_WAIT_DEC_ENC = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC    = 2'd2;
  localparam logic [1:0] ST_FLUSH_ENC    = 2'd3;

  typedef enum logic [1:0] {
    ST_FILL     = ST_FILL_ENC,
    ST_WAIT_DEC = ST_WAIT_DEC_ENC,
    ST_DRAIN    = ST_DRAIN_ENC,
    ST_FLUSH    = ST_FLUSH_ENC
  } state_t;

  // One extra bit so a pointer can hold the value DEPTH (buffer full).
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ipcore_decision_applier_if.sv
// Valid/ready stream bundle with a last marker, shared by the word and verdict streams.
interface ipcore_decision_applier_if #(
  parameter int WIDTH = 512
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ipcore_pkt_ram.sv
// Simple dual-port packet buffer: one write port, one read port with a registered
// output that holds its value whenever no read is issued.
module ipcore_pkt_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 512,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ipcore_decision_applier.sv
// Buffers one processed packet, waits for its forward/drop verdict, then either
// replays the packet downstream or discards it. Oversized packets are always dropped.
module ipcore_decision_applier
  import multes_ipcore_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  ipcore_decision_applier_if.slave  proc_word,
  ipcore_decision_applier_if.slave  decision,
  ipcore_decision_applier_if.master out_word,
  output logic [31:0]              fwd_pkt_count,
  output logic [31:0]              drop_pkt_count,
  output logic [15:0]              ovf_pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  state_t            state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              ovf;
  logic              proc_ready;
  logic              dec_ready;
  logic              out_valid;
  logic              out_last;
  logic              proc_hs;
  logic              dec_hs;
  logic              out_hs;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              unused_dec_tlast;

  assign proc_hs = proc_word.tvalid & proc_ready;
  assign dec_hs  = decision.tvalid & dec_ready;
  assign out_hs  = out_valid & out_word.tready;
  assign wr_en   = proc_hs & (wr_ptr != FULL);
  // A new read only replaces the output word once the current one is gone or leaving.
  assign rd_en   = (state == ST_DRAIN) & (rd_ptr != wr_ptr) & (~out_valid | out_word.tready);

  assign proc_word.tready = proc_ready;
  assign decision.tready  = dec_ready;
  assign out_word.tvalid  = out_valid;
  assign out_word.tlast   = out_last;
  assign out_word.tdata   = rd_data;
  assign unused_dec_tlast = decision.tlast;

  ipcore_pkt_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_ram (
    .aclk    (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (proc_word.tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= ST_FILL;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ovf            <= 1'b0;
      proc_ready     <= 1'b0;
      dec_ready      <= 1'b0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      fwd_pkt_count  <= '0;
      drop_pkt_count <= '0;
      ovf_pkt_count  <= '0;
    end else begin
      unique case (state)
        ST_FILL: begin
          proc_ready <= 1'b1;
          if (proc_hs) begin
            if (wr_ptr == FULL) ovf <= 1'b1;
            else                wr_ptr <= wr_ptr + PW'(1);
            if (proc_word.tlast) begin
              state      <= ST_WAIT_DEC;
              proc_ready <= 1'b0;
              dec_ready  <= 1'b1;
            end
          end
        end

        ST_WAIT_DEC: begin
          if (dec_hs) begin
            dec_ready <= 1'b0;
            rd_ptr    <= '0;
            state     <= (ovf | decision.tdata[0]) ? ST_FLUSH : ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (rd_en) begin
            out_valid <= 1'b1;
            out_last  <= (rd_ptr == wr_ptr - PW'(1));
            rd_ptr    <= rd_ptr + PW'(1);
          end else if (out_hs) begin
            out_valid <= 1'b0;
          end
          if (out_hs && out_last) begin
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fwd_pkt_count <= fwd_pkt_count + 32'd1;
            proc_ready    <= 1'b1;
            state         <= ST_FILL;
          end
        end

        ST_FLUSH: begin
          wr_ptr         <= '0;
          ovf            <= 1'b0;
          drop_pkt_count <= drop_pkt_count + 32'd1;
          if (ovf) ovf_pkt_count <= ovf_pkt_count + 16'd1;
          proc_ready     <= 1'b1;
          state          <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipcore_decision_applier.sv
// Self-checking bench: table-driven packet scenarios, hand-written corner sequences
// and randomized traffic, all checked against a queue-based packet model.
module tb_ipcore_decision_applier;
  import multes_ipcore_pkg::*;

  localparam int DEPTH = DEFAULT_DEPTH;
  localparam int W     = DATA_W;
  localparam int NVEC  = 9;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    int len;
    bit drop;
    int mode;
    int exp_beats;
    int exp_fwd;
    int exp_drop;
    int exp_ovf;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] fwd_pkt_count;
  logic [31:0] drop_pkt_count;
  logic [15:0] ovf_pkt_count;

  ipcore_decision_applier_if #(.WIDTH(W)) proc_word ();
  ipcore_decision_applier_if #(.WIDTH(1)) decision ();
  ipcore_decision_applier_if #(.WIDTH(W)) out_word ();

  ipcore_decision_applier #(.DEPTH(DEPTH)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .proc_word      (proc_word),
    .decision       (decision),
    .out_word       (out_word),
    .fwd_pkt_count  (fwd_pkt_count),
    .drop_pkt_count (drop_pkt_count),
    .ovf_pkt_count  (ovf_pkt_count)
  );

  always #5 aclk = ~aclk;

  int           n_checks = 0;
  int           n_pass = 0;
  int           ready_mode = 0;
  int           dec_hs_count = 0;
  int           exp_fwd = 0;
  int           exp_drop = 0;
  int           exp_ovf = 0;
  beat_t        got_q[$];
  beat_t        exp_q[$];
  logic [W-1:0] pkt [0:127];
  vec_t         vecs [NVEC];
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;

  task automatic check_output(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Observe completed beats and verdicts, and hold the output to its stall contract.
  always @(posedge aclk) begin
    beat_t b;
    if (aresetn && out_word.tvalid && out_word.tready) begin
      b.data = out_word.tdata;
      b.last = out_word.tlast;
      got_q.push_back(b);
    end
    if (aresetn && decision.tvalid && decision.tready) dec_hs_count++;
    if (aresetn && stall_prev) begin
      check_output("stall_valid", W'(out_word.tvalid), W'(1));
      check_output("stall_data", out_word.tdata, prev_data);
      check_output("stall_last", W'(out_word.tlast), W'(prev_last));
    end
    stall_prev = aresetn && out_word.tvalid && !out_word.tready;
    prev_data  = out_word.tdata;
    prev_last  = out_word.tlast;
  end

  initial begin
    out_word.tready = 1'b1;
    forever begin
      @(negedge aclk);
      case (ready_mode)
        0:       out_word.tready = 1'b1;
        1:       out_word.tready = ~out_word.tready;
        default: out_word.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic fill_packet(input int len);
    for (int i = 0; i < len; i++)
      for (int j = 0; j < W / 32; j++) pkt[i][j*32 +: 32] = $urandom();
  endtask

  task automatic send_words(input int len);
    int waited;
    for (int i = 0; i < len; i++) begin
      proc_word.tdata  = pkt[i];
      proc_word.tvalid = 1'b1;
      proc_word.tlast  = (i == len - 1);
      waited = 0;
      while (proc_word.tready !== 1'b1 && waited < 200) begin
        @(negedge aclk);
        waited++;
      end
      if (waited >= 200) begin
        check_output("proc_accept_timeout", W'(0), W'(1));
        break;
      end
      @(negedge aclk);
    end
    proc_word.tvalid = 1'b0;
    proc_word.tlast  = 1'b0;
  endtask

  task automatic send_decision(input bit drop);
    int waited = 0;
    decision.tdata  = drop;
    decision.tvalid = 1'b1;
    while (decision.tready !== 1'b1 && waited < 200) begin
      @(negedge aclk);
      waited++;
    end
    if (waited >= 200) check_output("decision_accept_timeout", W'(0), W'(1));
    @(negedge aclk);
    decision.tvalid = 1'b0;
  endtask

  task automatic wait_fill();
    int waited = 0;
    while (proc_word.tready !== 1'b1 && waited < 2000) begin
      @(negedge aclk);
      waited++;
    end
    if (waited >= 2000) check_output("return_to_fill_timeout", W'(0), W'(1));
  endtask

  // Model: a packet is forwarded word-for-word only if it fits and the verdict is 0.
  task automatic model_packet(input int len, input bit drop);
    beat_t b;
    if (len <= DEPTH && !drop) begin
      for (int i = 0; i < len; i++) begin
        b.data = pkt[i];
        b.last = (i == len - 1);
        exp_q.push_back(b);
      end
      exp_fwd++;
    end else begin
      exp_drop++;
      if (len > DEPTH) exp_ovf++;
    end
  endtask

  task automatic apply_stimulus(input int len, input bit drop);
    fill_packet(len);
    model_packet(len, drop);
    send_words(len);
    check_output("wait_dec_proc_ready", W'(proc_word.tready), W'(0));
    send_decision(drop);
    if (len > DEPTH || drop) begin
      check_output("flush_proc_ready", W'(proc_word.tready), W'(0));
      @(negedge aclk);
      check_output("flush_then_fill_ready", W'(proc_word.tready), W'(1));
    end
    wait_fill();
  endtask

  task automatic compare_beats();
    beat_t g;
    beat_t e;
    check_output("beat_count", W'(got_q.size()), W'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check_output("beat_data", g.data, e.data);
      check_output("beat_last", W'(g.last), W'(e.last));
    end
    got_q.delete();
    exp_q.delete();
    check_output("fwd_pkt_count", W'(fwd_pkt_count), W'(exp_fwd));
    check_output("drop_pkt_count", W'(drop_pkt_count), W'(exp_drop));
    check_output("ovf_pkt_count", W'(ovf_pkt_count), W'(exp_ovf));
  endtask

  task automatic check_reset_state();
    check_output("rst_out_valid", W'(out_word.tvalid), W'(0));
    check_output("rst_out_last", W'(out_word.tlast), W'(0));
    check_output("rst_dec_ready", W'(decision.tready), W'(0));
    check_output("rst_proc_ready", W'(proc_word.tready), W'(0));
    check_output("rst_fwd_count", W'(fwd_pkt_count), W'(0));
    check_output("rst_drop_count", W'(drop_pkt_count), W'(0));
    check_output("rst_ovf_count", W'(ovf_pkt_count), W'(0));
  endtask

  initial begin
    int hs0;
    int waited;
    beat_t g;

    vecs = '{
      '{3,  1'b0, 0, 3,  1, 0, 0},
      '{3,  1'b1, 0, 0,  1, 1, 0},
      '{66, 1'b0, 0, 0,  1, 2, 1},
      '{64, 1'b0, 0, 64, 2, 2, 1},
      '{4,  1'b0, 1, 4,  3, 2, 1},
      '{1,  1'b0, 0, 1,  4, 2, 1},
      '{65, 1'b0, 1, 0,  4, 3, 2},
      '{65, 1'b1, 0, 0,  4, 4, 3},
      '{2,  1'b0, 2, 2,  5, 4, 3}
    };

    aresetn          = 1'b0;
    proc_word.tdata  = '0;
    proc_word.tvalid = 1'b0;
    proc_word.tlast  = 1'b0;
    decision.tdata   = '0;
    decision.tvalid  = 1'b0;
    decision.tlast   = 1'b0;
    repeat (3) @(negedge aclk);
    check_reset_state();
    aresetn = 1'b1;
    wait_fill();

    for (int v = 0; v < NVEC; v++) begin
      ready_mode = vecs[v].mode;
      apply_stimulus(vecs[v].len, vecs[v].drop);
      ready_mode = 0;
      check_output("tbl_beats", W'(got_q.size()), W'(vecs[v].exp_beats));
      check_output("tbl_fwd", W'(fwd_pkt_count), W'(vecs[v].exp_fwd));
      check_output("tbl_drop", W'(drop_pkt_count), W'(vecs[v].exp_drop));
      check_output("tbl_ovf", W'(ovf_pkt_count), W'(vecs[v].exp_ovf));
      compare_beats();
    end

    // Verdict offered before the packet ends must wait for the whole packet.
    fill_packet(3);
    model_packet(3, 1'b0);
    hs0 = dec_hs_count;
    decision.tdata  = 1'b0;
    decision.tvalid = 1'b1;
    repeat (3) @(negedge aclk);
    check_output("early_dec_ready", W'(decision.tready), W'(0));
    send_words(3);
    check_output("early_dec_not_consumed", W'(dec_hs_count), W'(hs0));
    waited = 0;
    while (dec_hs_count == hs0 && waited < 50) begin
      @(negedge aclk);
      waited++;
    end
    decision.tvalid = 1'b0;
    check_output("early_dec_consumed", W'(dec_hs_count), W'(hs0 + 1));
    wait_fill();
    compare_beats();

    // Reset after the second of four drain beats.
    fill_packet(4);
    send_words(4);
    send_decision(1'b0);
    waited = 0;
    while (got_q.size() < 2 && waited < 50) begin
      @(negedge aclk);
      waited++;
    end
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check_reset_state();
    check_output("mid_drain_beats", W'(got_q.size()), W'(2));
    for (int i = 0; i < 2 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      check_output("mid_drain_data", g.data, pkt[i]);
    end
    got_q.delete();
    exp_q.delete();
    exp_fwd  = 0;
    exp_drop = 0;
    exp_ovf  = 0;
    aresetn  = 1'b1;
    wait_fill();
    check_output("post_reset_no_beats", W'(got_q.size()), W'(0));
    apply_stimulus(4, 1'b0);
    compare_beats();

    ready_mode = 2;
    for (int p = 0; p < 25; p++) begin
      apply_stimulus($urandom_range(1, DEPTH + 4), ($urandom_range(0, 3) == 0));
      compare_beats();
    end
    ready_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/ipcore_decision_applier.md
IPCORE_DECISION_APPLIER -- requirements
Module: ipcore_decision_applier

Interface
REQ-001 Parameter DEPTH, default 64, buffer capacity in 512-bit words; power of two, >=2.
REQ-002 aclk  in  1  clock; all logic on rising edge.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 proc_word_tdata/tvalid/tlast  in  512/1/1  processed packet words from user processing core.
REQ-005 proc_word_tready  out  1  accept for proc_word.
REQ-006 decision_tdata/tvalid/tlast  in  1/1/1  per-packet verdict; tdata 1=drop, 0=forward; tlast ignored.
REQ-007 decision_tready  out  1  accept for decision.
REQ-008 out_word_tdata/tvalid/tlast  out  512/1/1  forwarded packet words.
REQ-009 out_word_tready  in  1  downstream accept.
REQ-010 fwd_pkt_count, drop_pkt_count  out  32 each  packets forwarded / dropped (drop includes overflow).
REQ-011 ovf_pkt_count  out  16  packets force-dropped due to buffer overflow.

Function
REQ-012 Handshake on any stream SHALL occur only when tvalid and tready are both 1 on a rising edge.
REQ-013 FSM states SHALL be ST_FILL, ST_WAIT_DEC, ST_DRAIN, ST_FLUSH; one packet in flight.
REQ-014 ST_FILL: proc_word_tready=1; each accepted word written at wr_ptr, wr_ptr+1; tlast-accepted word -> ST_WAIT_DEC next cycle.
REQ-015 Overflow: word accepted with wr_ptr==DEPTH SHALL be discarded and set ovf flag; block keeps accepting and discarding until tlast.
REQ-016 ST_WAIT_DEC: decision_tready=1, proc_word_tready=0; on decision accept: ovf flag set or tdata=1 -> ST_FLUSH, else -> ST_DRAIN.
REQ-017 A decision arriving before ST_WAIT_DEC SHALL be held off (tready=0), never consumed early.
REQ-018 ST_DRAIN: words 0..wr_ptr-1 presented in order on out_word; tlast=1 on word wr_ptr-1 only; first out_word_tvalid within 2 cycles of decision accept.
REQ-019 out_word_tvalid, tdata, tlast SHALL stay stable while tvalid=1 and tready=0; back-to-back beats at 1 word/cycle when tready held 1.
REQ-020 After the tlast beat handshakes: fwd_pkt_count+1, wr_ptr cleared, -> ST_FILL next cycle.
REQ-021 ST_FLUSH: lasts exactly 1 cycle; wr_ptr and ovf flag cleared; drop_pkt_count+1; ovf_pkt_count+1 if ovf flag; -> ST_FILL.
REQ-022 Counters SHALL wrap modulo 2^width, no saturation.
REQ-023 proc_word_tready SHALL be 0 in ST_WAIT_DEC, ST_DRAIN, ST_FLUSH.
REQ-024 Single-word packet (tlast on first beat) SHALL be handled identically, out tlast on that word.
REQ-025 Packet of exactly DEPTH words SHALL not set ovf; DEPTH+1 words SHALL.

Reset
REQ-026 On aresetn=0: state ST_FILL, wr_ptr/rd_ptr 0, ovf 0, all counters 0, out_word_tvalid 0, out_word_tlast 0, decision_tready 0, proc_word_tready 0 during reset.
REQ-027 Reset mid-packet or mid-drain SHALL discard buffered data with no further out_word beats; buffer RAM contents need no reset.

Structure
REQ-028 State encoding localparams and default DEPTH SHALL live in shared package multes_ipcore_pkg.
REQ-029 Buffer storage SHALL be one sub-module ipcore_pkt_ram (simple dual-port, 1-cycle read latency, DEPTH x 512).
REQ-030 Pointer width SHALL be clog2(DEPTH)+1 bits.

Verification
REQ-031 3-word packet, decision 0, out_word_tready=1 -> 3 out beats identical data, tlast on 3rd, fwd_pkt_count=1.
REQ-032 3-word packet, decision 1 -> zero out beats, drop_pkt_count=1, proc_word_tready=1 two cycles after decision accept.
REQ-033 DEPTH+2 words (66 at default), decision 0 -> zero out beats, drop_pkt_count=1, ovf_pkt_count=1; next 64-word packet forwarded fully.
REQ-034 4-word packet, decision 0, out_word_tready toggling 1/0 -> 4 beats in order, data stable across stalls.
REQ-035 decision presented before packet tlast -> decision_tready stays 0 until ST_WAIT_DEC; then consumed, packet forwarded.
REQ-036 reset asserted after 2nd of 4 drain beats -> no further out beats, counters 0, next packet forwarded correctly.
